// File: rtl/seg7_scan.sv
// Eight-digit hex scanner for a common-anode 7-segment bank, fed from the GPIO
// output word; a frame-wide shadow copy keeps each frame consistent.
module seg7_scan #(
   parameter int unsigned CLK_DIV  = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] value,
   output logic [7:0]  an,
   output logic [6:0]  seg
);

   localparam int unsigned   PW   = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          tick_s;
   logic [3:0]    nibble_s;
   logic [31:0]   upper_s;
   logic          blank_s;

   // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         4'hF:    p = 7'h71;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   assign tick_s   = (pcnt_q == PMAX);
   assign nibble_s = shadow_q[{idx_q, 2'b00} +: 4];
   assign upper_s  = shadow_q >> {idx_q, 2'b00};

   // Prescaler wrap, scan advance and once-per-frame shadow capture
   always_comb begin
      pcnt_d   = pcnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (tick_s) begin
         pcnt_d = {PW{1'b0}};
         idx_d  = idx_q + 3'd1;
         if (idx_q == 3'd7) begin
            shadow_d = value;
         end else begin
            shadow_d = shadow_q;
         end
      end else begin
         pcnt_d = pcnt_q + PW'(1);
      end
   end

   // Slot decode: digit 0 is always lit so a zero word still shows "0"
   always_comb begin
      blank_s = 1'b0;
      an_d    = 8'hFF;
      seg_d   = 7'h7F;
      if (BLANK_LZ && (idx_q != 3'd0) && (upper_s == 32'd0)) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
      if (blank_s) begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
      end else begin
         an_d  = ~(8'b0000_0001 << idx_q);
         seg_d = ~hex_to_seg(nibble_s);
      end
   end

   // State and pin registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pcnt_q   <= {PW{1'b0}};
         idx_q    <= 3'd0;
         shadow_q <= 32'd0;
         an_q     <= 8'hFF;
         seg_q    <= 7'h7F;
      end else begin
         pcnt_q   <= pcnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: edge-count reference model checked every cycle, plus
// table vectors and hand sequences for reset, mid-frame change and blanking.
module tb_seg7_scan;

   localparam int CD = 4;
   localparam int FRAME = 8 * CD;

   logic        CLK   = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] value = 32'd0;
   logic [7:0]  an1, an0;
   logic [6:0]  seg1, seg0;

   int total = 0;
   int bad   = 0;

   seg7_scan #(.CLK_DIV(CD), .BLANK_LZ(1'b1)) dut (
      .CLK(CLK), .RST_N(RST_N), .value(value), .an(an1), .seg(seg1)
   );
   seg7_scan #(.CLK_DIV(CD), .BLANK_LZ(1'b0)) dut_nb (
      .CLK(CLK), .RST_N(RST_N), .value(value), .an(an0), .seg(seg0)
   );

   always #5 CLK = ~CLK;

   // Active-low digit glyphs
   logic [6:0] glyph [16] = '{~7'h3F, ~7'h06, ~7'h5B, ~7'h4F, ~7'h66, ~7'h6D, ~7'h7D, ~7'h07,
                              ~7'h7F, ~7'h6F, ~7'h77, ~7'h7C, ~7'h39, ~7'h5E, ~7'h79, ~7'h71};

   // Expected {an,seg} after the k-th edge since release, given the frame's word
   function automatic logic [14:0] out_for(input int unsigned k, input logic [31:0] sh, input bit blz);
      int unsigned d;
      logic [31:0] up;
      d  = ((k - 1) / CD) % 8;
      up = sh >> (4 * d);
      if (blz && d != 0 && up == 32'd0) return {8'hFF, 7'h7F};
      return {~(8'd1 << d), glyph[up % 16]};
   endfunction

   int unsigned k_q;
   logic [31:0] msh_q;
   logic [14:0] exp1_q, exp0_q;

   // Reference model: edge counter since release and per-frame captured word
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         k_q    <= 0;
         msh_q  <= 32'd0;
         exp1_q <= {8'hFF, 7'h7F};
         exp0_q <= {8'hFF, 7'h7F};
      end else begin
         k_q    <= k_q + 1;
         exp1_q <= out_for(k_q + 1, msh_q, 1'b1);
         exp0_q <= out_for(k_q + 1, msh_q, 1'b0);
         if ((k_q + 1) % FRAME == 0) msh_q <= value;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   // Continuous comparison against the model, plus the single-anode invariant
   always @(negedge CLK) begin
      check("model_an_lz",  an1,  exp1_q[14:7]);
      check("model_seg_lz", seg1, exp1_q[6:0]);
      check("model_an_nb",  an0,  exp0_q[14:7]);
      check("model_seg_nb", seg0, exp0_q[6:0]);
      check("onehot_lz", ($countones(~an1) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("onehot_nb", ($countones(~an0) <= 1) ? 32'd1 : 32'd0, 32'd1);
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic start(input logic [31:0] v);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      value = v;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   typedef struct {
      logic [31:0] v;
      int          d;
      logic [7:0]  an1;
      logic [6:0]  seg1;
      logic [7:0]  an0;
      logic [6:0]  seg0;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{32'h89ABCDEF, 0, 8'hFE, 7'h0E, 8'hFE, 7'h0E});
      tbl.push_back('{32'h89ABCDEF, 1, 8'hFD, 7'h06, 8'hFD, 7'h06});
      tbl.push_back('{32'h89ABCDEF, 2, 8'hFB, 7'h21, 8'hFB, 7'h21});
      tbl.push_back('{32'h89ABCDEF, 3, 8'hF7, 7'h46, 8'hF7, 7'h46});
      tbl.push_back('{32'h89ABCDEF, 4, 8'hEF, 7'h03, 8'hEF, 7'h03});
      tbl.push_back('{32'h89ABCDEF, 5, 8'hDF, 7'h08, 8'hDF, 7'h08});
      tbl.push_back('{32'h89ABCDEF, 6, 8'hBF, 7'h10, 8'hBF, 7'h10});
      tbl.push_back('{32'h89ABCDEF, 7, 8'h7F, 7'h00, 8'h7F, 7'h00});
      tbl.push_back('{32'h00000000, 0, 8'hFE, 7'h40, 8'hFE, 7'h40});
      tbl.push_back('{32'h00000000, 1, 8'hFF, 7'h7F, 8'hFD, 7'h40});
      tbl.push_back('{32'h00000000, 4, 8'hFF, 7'h7F, 8'hEF, 7'h40});
      tbl.push_back('{32'h00000000, 7, 8'hFF, 7'h7F, 8'h7F, 7'h40});
      tbl.push_back('{32'h00100000, 0, 8'hFE, 7'h40, 8'hFE, 7'h40});
      tbl.push_back('{32'h00100000, 4, 8'hEF, 7'h40, 8'hEF, 7'h40});
      tbl.push_back('{32'h00100000, 5, 8'hDF, 7'h79, 8'hDF, 7'h79});
      tbl.push_back('{32'h00100000, 6, 8'hFF, 7'h7F, 8'hBF, 7'h40});
      tbl.push_back('{32'h00000008, 0, 8'hFE, 7'h00, 8'hFE, 7'h00});
      tbl.push_back('{32'h00000008, 1, 8'hFF, 7'h7F, 8'hFD, 7'h40});
      tbl.push_back('{32'h00000008, 7, 8'hFF, 7'h7F, 8'h7F, 7'h40});

      // Reset hold with a live word on the input
      value = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("rst_hold_an", an1, 8'hFF);
         check("rst_hold_seg", seg1, 7'h7F);
      end
      RST_N = 1'b1;
      wait_edges(1);
      check("first_an", an1, 8'hFE);
      check("first_seg", seg1, 7'h40);
      for (int i = 2; i <= 4; i++) begin
         wait_edges(1);
         check("slot0_hold_an", an1, 8'hFE);
      end
      wait_edges(1);
      check("first_change_an", an1, 8'hFF);

      // Table vectors, sampled in the second frame
      foreach (tbl[i]) begin
         start(tbl[i].v);
         wait_edges(FRAME + tbl[i].d * CD + 1 + int'($urandom_range(0, CD - 1)));
         check($sformatf("vec%0d_an_lz", i),  an1,  tbl[i].an1);
         check($sformatf("vec%0d_seg_lz", i), seg1, tbl[i].seg1);
         check($sformatf("vec%0d_an_nb", i),  an0,  tbl[i].an0);
         check($sformatf("vec%0d_seg_nb", i), seg0, tbl[i].seg0);
      end

      // Mid-frame change: switch while digit 3 of the second frame is shown
      start(32'h11111111);
      wait_edges(FRAME + 3 * CD + 1);
      #1 value = 32'h22222222;
      for (int e = FRAME + 3 * CD + 2; e <= 2 * FRAME; e++) begin
         wait_edges(1);
         check("midframe_old_seg", seg1, 7'h79);
      end
      for (int e = 2 * FRAME + 1; e <= 3 * FRAME; e++) begin
         wait_edges(1);
         check("midframe_new_seg", seg1, 7'h24);
      end

      // Asynchronous reset while digit 5 is shown
      start(32'h12345678);
      wait_edges(FRAME + 5 * CD + 1);
      check("pre_rst_an", an1, 8'hDF);
      check("pre_rst_seg", seg1, 7'h30);
      @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      check("async_rst_an", an1, 8'hFF);
      check("async_rst_seg", seg1, 7'h7F);
      check("async_rst_an_nb", an0, 8'hFF);
      @(negedge CLK);
      RST_N = 1'b1;
      wait_edges(1);
      check("restart_an", an1, 8'hFE);
      check("restart_seg", seg1, 7'h40);
      wait_edges(CD);
      check("restart_d1_an", an1, 8'hFF);
      check("restart_d1_an_nb", an0, 8'hFD);

      // Random words with varying leading zeros, changed at random times
      start($urandom);
      for (int c = 0; c < 20 * FRAME; c++) begin
         @(negedge CLK);
         if ($urandom_range(0, 5) == 0) begin
            #1 value = $urandom >> $urandom_range(0, 31);
         end
      end

      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
